// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared state type and width helper for the PE row-convolution controller
package pe_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE       = 3'd0,
      S_LOAD_FILT  = 3'd1,
      S_LOAD_IFMAP = 3'd2,
      S_COMPUTE    = 3'd3,
      S_DRAIN      = 3'd4,
      S_SLIDE      = 3'd5,
      S_DONE       = 3'd6
   } state_t;

   // Address/select widths never collapse to zero bits, even for a single entry.
   function automatic int clog2_min1(input int value);
      return (value <= 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/pe_row_conv_ctrl_if.sv
// rtl/pe_row_conv_ctrl_if.sv - handshake and datapath-control bundle around the PE controller
interface pe_row_conv_ctrl_if
   import pe_ctrl_pkg::*;
#(
   parameter int FILT_LEN = 3,
   parameter int NUM_FILT = 2,
   parameter int FA_W     = clog2_min1(FILT_LEN * NUM_FILT),
   parameter int IA_W     = clog2_min1(FILT_LEN),
   parameter int PS_W     = clog2_min1(NUM_FILT)
);
   logic            start;
   logic            abort;
   logic            filt_valid;
   logic            filt_ready;
   logic [FA_W-1:0] filt_wr_addr;
   logic            ifmap_valid;
   logic            ifmap_ready;
   logic [IA_W-1:0] ifmap_wr_addr;
   logic            mac_en;
   logic            psum_clear;
   logic [FA_W-1:0] filt_rd_addr;
   logic [IA_W-1:0] ifmap_rd_addr;
   logic [PS_W-1:0] psum_sel;
   logic            psum_out_valid;
   logic            psum_out_ready;
   logic            busy;
   logic            done;

   modport master (
      input  start, abort, filt_valid, ifmap_valid, psum_out_ready,
      output filt_ready, filt_wr_addr, ifmap_ready, ifmap_wr_addr, mac_en, psum_clear,
             filt_rd_addr, ifmap_rd_addr, psum_sel, psum_out_valid, busy, done
   );

   modport slave (
      output start, abort, filt_valid, ifmap_valid, psum_out_ready,
      input  filt_ready, filt_wr_addr, ifmap_ready, ifmap_wr_addr, mac_en, psum_clear,
             filt_rd_addr, ifmap_rd_addr, psum_sel, psum_out_valid, busy, done
   );

endinterface

// File: rtl/pe_ctrl_idx_counter.sv
// rtl/pe_ctrl_idx_counter.sv - loop index counter that wraps to zero after MAX
module pe_ctrl_idx_counter #(
   parameter int W   = 2,
   parameter int MAX = 3
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_en,
   input  logic         i_clr,
   output logic [W-1:0] o_q,
   output logic         o_at_max
);

   logic [W-1:0] r_q;
   logic         w_at_max;

   assign w_at_max = (r_q == W'(MAX));

   // Clear has priority so a state exit can reset the index in the same cycle it would advance.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= w_at_max ? '0 : r_q + 1'b1;
      end
   end

   assign o_q      = r_q;
   assign o_at_max = w_at_max;

endmodule

// File: rtl/pe_row_conv_ctrl.sv
// rtl/pe_row_conv_ctrl.sv - row-convolution sequencer for one PE: load filters, load window, MAC, drain, slide
module pe_row_conv_ctrl
   import pe_ctrl_pkg::*;
#(
   parameter int FILT_LEN = 3,
   parameter int NUM_FILT = 2,
   parameter int OUT_LEN  = 4,
   parameter int FA_W     = clog2_min1(FILT_LEN * NUM_FILT),
   parameter int IA_W     = clog2_min1(FILT_LEN),
   parameter int PS_W     = clog2_min1(NUM_FILT)
) (
   input logic                clk,
   input logic                rstn,
   pe_row_conv_ctrl_if.master bus
);

   localparam int OA_W = clog2_min1(OUT_LEN);
   localparam int IS_W = IA_W + 1;

   state_t          r_state;
   state_t          w_nxt;
   logic [IA_W-1:0] r_base;
   logic            r_busy;
   logic            r_filt_ready;
   logic            r_ifmap_ready;
   logic            r_mac_en;
   logic            r_psum_out_valid;
   logic            r_done;

   logic            w_idx_clr;
   logic            w_t_en, w_f_en, w_o_en, w_wcnt_en, w_wcnt_clr;
   logic            w_base_inc, w_base_clr;
   logic            w_t_max, w_f_max, w_o_max, w_wcnt_max;
   logic [IA_W-1:0] w_t;
   logic [PS_W-1:0] w_f;
   logic [OA_W-1:0] w_o;
   logic [FA_W-1:0] w_wcnt;
   logic [IS_W-1:0] w_win_sum;
   logic [IS_W-1:0] w_win_idx;
   logic            w_unused_o;

   pe_ctrl_idx_counter #(.W(IA_W), .MAX(FILT_LEN - 1)) u_tap_cnt (
      .clk(clk), .rstn(rstn), .i_en(w_t_en), .i_clr(w_idx_clr), .o_q(w_t), .o_at_max(w_t_max)
   );

   pe_ctrl_idx_counter #(.W(PS_W), .MAX(NUM_FILT - 1)) u_filt_cnt (
      .clk(clk), .rstn(rstn), .i_en(w_f_en), .i_clr(w_idx_clr), .o_q(w_f), .o_at_max(w_f_max)
   );

   pe_ctrl_idx_counter #(.W(OA_W), .MAX(OUT_LEN - 1)) u_out_cnt (
      .clk(clk), .rstn(rstn), .i_en(w_o_en), .i_clr(w_idx_clr), .o_q(w_o), .o_at_max(w_o_max)
   );

   pe_ctrl_idx_counter #(.W(FA_W), .MAX(FILT_LEN * NUM_FILT - 1)) u_load_cnt (
      .clk(clk), .rstn(rstn), .i_en(w_wcnt_en), .i_clr(w_wcnt_clr), .o_q(w_wcnt), .o_at_max(w_wcnt_max)
   );

   assign w_unused_o = ^w_o;

   always_comb begin
      w_nxt       = r_state;
      w_idx_clr   = 1'b0;
      w_t_en      = 1'b0;
      w_f_en      = 1'b0;
      w_o_en      = 1'b0;
      w_wcnt_en   = 1'b0;
      w_wcnt_clr  = 1'b0;
      w_base_inc  = 1'b0;
      w_base_clr  = 1'b0;
      if (bus.abort && (r_state != S_IDLE)) begin
         w_nxt      = S_IDLE;
         w_idx_clr  = 1'b1;
         w_wcnt_clr = 1'b1;
         w_base_clr = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  w_nxt = S_LOAD_FILT;
               end
            end
            S_LOAD_FILT: begin
               // The load counter wraps to zero on the last filter beat, ready for the ifmap load.
               if (bus.filt_valid) begin
                  w_wcnt_en = 1'b1;
                  if (w_wcnt_max) begin
                     w_nxt = S_LOAD_IFMAP;
                  end
               end
            end
            S_LOAD_IFMAP: begin
               if (bus.ifmap_valid) begin
                  if (w_wcnt == FA_W'(FILT_LEN - 1)) begin
                     w_wcnt_clr = 1'b1;
                     w_base_clr = 1'b1;
                     w_nxt      = S_COMPUTE;
                  end else begin
                     w_wcnt_en = 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               w_t_en = 1'b1;
               if (w_t_max) begin
                  w_nxt = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (bus.psum_out_ready) begin
                  w_f_en = 1'b1;
                  if (!w_f_max) begin
                     w_nxt = S_COMPUTE;
                  end else if (!w_o_max) begin
                     w_nxt = S_SLIDE;
                  end else begin
                     w_nxt = S_DONE;
                  end
               end
            end
            S_SLIDE: begin
               if (bus.ifmap_valid) begin
                  w_base_inc = 1'b1;
                  w_o_en     = 1'b1;
                  w_nxt      = S_COMPUTE;
               end
            end
            S_DONE: begin
               w_nxt      = S_IDLE;
               w_idx_clr  = 1'b1;
               w_wcnt_clr = 1'b1;
               w_base_clr = 1'b1;
            end
            default: begin
               w_nxt      = S_IDLE;
               w_idx_clr  = 1'b1;
               w_wcnt_clr = 1'b1;
               w_base_clr = 1'b1;
            end
         endcase
      end
   end

   // Strobes are registered from the next state, so each one is a pure decode of the state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state          <= S_IDLE;
         r_base           <= '0;
         r_busy           <= 1'b0;
         r_filt_ready     <= 1'b0;
         r_ifmap_ready    <= 1'b0;
         r_mac_en         <= 1'b0;
         r_psum_out_valid <= 1'b0;
         r_done           <= 1'b0;
      end else begin
         r_state <= w_nxt;
         if (w_base_clr) begin
            r_base <= '0;
         end else if (w_base_inc) begin
            r_base <= (r_base == IA_W'(FILT_LEN - 1)) ? '0 : r_base + 1'b1;
         end
         r_busy           <= (w_nxt != S_IDLE);
         r_filt_ready     <= (w_nxt == S_LOAD_FILT);
         r_ifmap_ready    <= (w_nxt == S_LOAD_IFMAP) || (w_nxt == S_SLIDE);
         r_mac_en         <= (w_nxt == S_COMPUTE);
         r_psum_out_valid <= (w_nxt == S_DRAIN);
         r_done           <= (w_nxt == S_DONE);
      end
   end

   // Circular window read: base and tap are both below FILT_LEN, so one conditional subtract wraps it.
   assign w_win_sum = {1'b0, r_base} + {1'b0, w_t};
   assign w_win_idx = (w_win_sum >= IS_W'(FILT_LEN)) ? (w_win_sum - IS_W'(FILT_LEN)) : w_win_sum;

   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.filt_ready     = r_filt_ready;
   assign bus.ifmap_ready    = r_ifmap_ready;
   assign bus.mac_en         = r_mac_en;
   assign bus.psum_out_valid = r_psum_out_valid;
   assign bus.psum_clear     = r_mac_en && (w_t == '0);
   assign bus.psum_sel       = (r_mac_en || r_psum_out_valid) ? w_f : '0;
   assign bus.filt_wr_addr   = r_filt_ready ? w_wcnt : '0;
   assign bus.ifmap_wr_addr  = (r_state == S_LOAD_IFMAP) ? w_wcnt[IA_W-1:0] :
                               (r_state == S_SLIDE)      ? r_base : '0;
   assign bus.filt_rd_addr   = r_mac_en ? (FA_W'(w_f) * FA_W'(FILT_LEN) + FA_W'(w_t)) : '0;
   assign bus.ifmap_rd_addr  = r_mac_en ? w_win_idx[IA_W-1:0] : '0;

endmodule

// File: tb/tb_pe_row_conv_ctrl.sv
// tb/tb_pe_row_conv_ctrl.sv - directed self-checking bench for pe_row_conv_ctrl
module tb_pe_row_conv_ctrl;

   localparam int FILT_LEN = 3;
   localparam int NUM_FILT = 2;
   localparam int OUT_LEN  = 4;

   logic clk = 1'b0;
   logic rstn;

   int n_chk  = 0;
   int n_pass = 0;

   int flog[$];
   int ilog[$];
   int plog[$];
   int mfr[$];
   int mir[$];
   int mclr[$];
   int done_cnt;
   int done_cyc;
   int hold_n;
   int hold_bad;

   pe_row_conv_ctrl_if #(.FILT_LEN(FILT_LEN), .NUM_FILT(NUM_FILT)) bus ();

   pe_row_conv_ctrl #(.FILT_LEN(FILT_LEN), .NUM_FILT(NUM_FILT), .OUT_LEN(OUT_LEN)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Runs one row from IDLE; bp holds the first drain 5 cycles, stall throttles filt/ifmap valid.
   task automatic run_row(input bit bp, input bit stall);
      int  sstall;
      bit  fin;
      flog.delete(); ilog.delete(); plog.delete();
      mfr.delete();  mir.delete();  mclr.delete();
      done_cnt = 0; done_cyc = -1; hold_n = 0; hold_bad = 0;
      sstall = 0; fin = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         bus.filt_valid     = stall ? (cyc % 2 == 0) : 1'b1;
         bus.ifmap_valid    = 1'b1;
         bus.psum_out_ready = 1'b1;
         if (stall && bus.ifmap_ready && plog.size() > 0 && sstall < 3) begin
            bus.ifmap_valid = 1'b0;
            sstall++;
         end
         if (bp && bus.psum_out_valid && hold_n < 5) begin
            bus.psum_out_ready = 1'b0;
            hold_n++;
            if (bus.psum_sel != 0 || bus.mac_en) hold_bad++;
         end
         if (bus.filt_ready && bus.filt_valid)   flog.push_back(int'(bus.filt_wr_addr));
         if (bus.ifmap_ready && bus.ifmap_valid) ilog.push_back(int'(bus.ifmap_wr_addr));
         if (bus.psum_out_valid && bus.psum_out_ready) plog.push_back(int'(bus.psum_sel));
         if (bus.mac_en) begin
            mfr.push_back(int'(bus.filt_rd_addr));
            mir.push_back(int'(bus.ifmap_rd_addr));
            mclr.push_back(int'(bus.psum_clear));
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (cyc > 0 && !bus.busy) fin = 1'b1;
         @(negedge clk);
      end
      chk("row_finished", int'(fin), 1);
   endtask

   task automatic check_row(input string tag, input int exp_done_cyc);
      int exp_i[6];
      int nclr;
      exp_i = '{0, 1, 2, 0, 1, 2};
      chk({tag, "_filt_beats"}, flog.size(), FILT_LEN * NUM_FILT);
      for (int i = 0; i < flog.size() && i < 6; i++) chk({tag, "_filt_wr_addr"}, flog[i], i);
      chk({tag, "_ifmap_beats"}, ilog.size(), 6);
      for (int i = 0; i < ilog.size() && i < 6; i++) chk({tag, "_ifmap_wr_addr"}, ilog[i], exp_i[i]);
      chk({tag, "_mac_cycles"}, mfr.size(), 24);
      nclr = 0;
      foreach (mclr[i]) nclr += mclr[i];
      chk({tag, "_psum_clears"}, nclr, 8);
      chk({tag, "_drains"}, plog.size(), 8);
      for (int i = 0; i < plog.size() && i < 8; i++) chk({tag, "_drain_sel"}, plog[i], i % 2);
      chk({tag, "_done_pulses"}, done_cnt, 1);
      chk({tag, "_done_cycle"}, done_cyc, exp_done_cyc);
   endtask

   initial begin
      int w;
      int quiet;
      rstn = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.filt_valid = 1'b0; bus.ifmap_valid = 1'b0; bus.psum_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_filt_ready", int'(bus.filt_ready), 0);
      chk("rst_ifmap_ready", int'(bus.ifmap_ready), 0);
      chk("rst_mac_en", int'(bus.mac_en), 0);
      chk("rst_psum_out_valid", int'(bus.psum_out_valid), 0);
      chk("rst_filt_wr_addr", int'(bus.filt_wr_addr), 0);
      chk("rst_psum_sel", int'(bus.psum_sel), 0);
      rstn = 1'b1;
      @(negedge clk);

      // Nominal row plus window-wrap detail: o=2 uses base 2, f=1 reads filter entries 3..5.
      run_row(1'b0, 1'b0);
      check_row("s1", 44);
      if (mir.size() == 24) begin
         chk("s2_ird_o2_t0", mir[12], 2);
         chk("s2_ird_o2_t1", mir[13], 0);
         chk("s2_ird_o2_t2", mir[14], 1);
         chk("s2_clr_o2_t0", mclr[12], 1);
         chk("s2_clr_o2_t1", mclr[13], 0);
         chk("s2_clr_o2_t2", mclr[14], 0);
         chk("s2_frd_f1_t0", mfr[3], 3);
         chk("s2_frd_f1_t1", mfr[4], 4);
         chk("s2_frd_f1_t2", mfr[5], 5);
         chk("s2_ird_o1_t0", mir[6], 1);
      end

      run_row(1'b1, 1'b0);
      check_row("s3", 49);
      chk("s3_hold_cycles", hold_n, 5);
      chk("s3_hold_stable", hold_bad, 0);

      run_row(1'b0, 1'b1);
      check_row("s4", 52);

      // Async reset in the middle of a COMPUTE cycle.
      bus.filt_valid = 1'b1; bus.ifmap_valid = 1'b1; bus.psum_out_ready = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      w = 0;
      while (!bus.mac_en && w < 40) begin @(negedge clk); w++; end
      chk("s5_reach_compute", int'(bus.mac_en), 1);
      @(posedge clk);
      #1;
      chk("s5_pre_ifmap_rd", int'(bus.ifmap_rd_addr), 1);
      #1 rstn = 1'b0;
      #1;
      chk("s5_mac_en", int'(bus.mac_en), 0);
      chk("s5_busy", int'(bus.busy), 0);
      chk("s5_filt_rd", int'(bus.filt_rd_addr), 0);
      chk("s5_ifmap_rd", int'(bus.ifmap_rd_addr), 0);
      chk("s5_psum_sel", int'(bus.psum_sel), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      run_row(1'b0, 1'b0);
      check_row("s5", 44);

      // Abort in DRAIN, start ignored while busy, start+abort in IDLE.
      bus.psum_out_ready = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      w = 0;
      while (!bus.mac_en && w < 40) begin @(negedge clk); w++; end
      chk("s6_reach_compute", int'(bus.mac_en), 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("s6_start_ign_busy", int'(bus.busy), 1);
      chk("s6_start_ign_mac", int'(bus.mac_en), 1);
      w = 0;
      while (!bus.psum_out_valid && w < 10) begin @(negedge clk); w++; end
      chk("s6_reach_drain", int'(bus.psum_out_valid), 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("s6_abort_busy", int'(bus.busy), 0);
      chk("s6_abort_valid", int'(bus.psum_out_valid), 0);
      chk("s6_abort_done", int'(bus.done), 0);
      quiet = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done || bus.busy || bus.psum_out_valid) quiet++;
      end
      chk("s6_idle_quiet", quiet, 0);
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("s6_start_abort_busy", int'(bus.busy), 0);
      chk("s6_start_abort_fready", int'(bus.filt_ready), 0);
      run_row(1'b0, 1'b0);
      check_row("s6", 44);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
